// File: rtl/sine_cfg_uart_ctrl.sv
// Framed-command parser between the UART byte interface and the PWM sine generator:
// decodes SYNC CMD DH DL CHK frames, updates generator registers and answers with ACK/NAK/status.
module sine_cfg_uart_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 100,
    parameter logic [15:0] PINC_RST    = 16'h0100,
    parameter logic [7:0]  AMP_RST     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] phase_inc,
    output logic [7:0]  amplitude,
    output logic        pwm_en,
    output logic        cfg_update,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_DH, GET_DL, GET_CHK, EXEC, RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, dh_q, dl_q, chk_q;
    logic [TW-1:0] tmo_q;
    logic [15:0]   phase_inc_q;
    logic [7:0]    amplitude_q;
    logic          pwm_en_q;
    logic          cfg_update_q;
    logic [7:0]    err_cnt_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;

    logic          in_get;
    logic          timeout_hit;
    logic          chk_ok;
    logic          cmd_write;
    logic          cmd_status;
    logic          frame_ok;
    logic [7:0]    status_byte;

    assign in_get      = (state_q == GET_CMD) || (state_q == GET_DH) ||
                         (state_q == GET_DL)  || (state_q == GET_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = in_get && !rx_valid && (tmo_q == TMO_LAST);

    assign chk_ok      = ((cmd_q ^ dh_q ^ dl_q) == chk_q);
    assign frame_ok    = chk_ok && (cmd_write || cmd_status);
    assign status_byte = {pwm_en_q, 6'b0, (amplitude_q == 8'h00)};

    always_comb begin
        cmd_write  = 1'b0;
        cmd_status = 1'b0;
        case (cmd_q)
            8'h01, 8'h02, 8'h03: cmd_write  = 1'b1;
            8'h04:               cmd_status = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_d = GET_CMD;
            GET_CMD: if (rx_valid) state_d = GET_DH;
            GET_DH:  if (rx_valid) state_d = GET_DL;
            GET_DL:  if (rx_valid) state_d = GET_CHK;
            GET_CHK: if (rx_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (tx_valid_q && tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (!in_get || rx_valid || timeout_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            dh_q  <= '0;
            dl_q  <= '0;
            chk_q <= '0;
        end else if (rx_valid) begin
            case (state_q)
                GET_CMD: cmd_q <= rx_data;
                GET_DH:  dh_q  <= rx_data;
                GET_DL:  dl_q  <= rx_data;
                GET_CHK: chk_q <= rx_data;
                default: ;
            endcase
        end
    end

    // Register writes and the response byte are committed in the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_inc_q  <= PINC_RST;
            amplitude_q  <= AMP_RST;
            pwm_en_q     <= 1'b0;
            cfg_update_q <= 1'b0;
            err_cnt_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            if (state_q == EXEC) begin
                tx_valid_q <= 1'b1;
                if (frame_ok) begin
                    case (cmd_q)
                        8'h01:   phase_inc_q <= {dh_q, dl_q};
                        8'h02:   amplitude_q <= dl_q;
                        8'h03:   pwm_en_q    <= dl_q[0];
                        default: ;
                    endcase
                    cfg_update_q <= cmd_write;
                    tx_data_q    <= cmd_status ? status_byte : ACK_BYTE;
                end else begin
                    tx_data_q <= NAK_BYTE;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (state_q == RESP && tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign phase_inc  = phase_inc_q;
    assign amplitude  = amplitude_q;
    assign pwm_en     = pwm_en_q;
    assign cfg_update = cfg_update_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sine_cfg_uart_ctrl.sv
// Self-checking bench for sine_cfg_uart_ctrl: expected response bytes are queued as frames
// are sent and compared by a monitor whenever the DUT completes a TX handshake.
module tb_sine_cfg_uart_ctrl;

    localparam int unsigned TMO = 40;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] phase_inc;
    logic [7:0]  amplitude;
    logic        pwm_en;
    logic        cfg_update;
    logic [7:0]  err_cnt;

    sine_cfg_uart_ctrl #(
        .CLK_HZ(4000), .TIMEOUT_CYC(TMO), .PINC_RST(16'h0100), .AMP_RST(8'hFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .phase_inc(phase_inc), .amplitude(amplitude), .pwm_en(pwm_en),
        .cfg_update(cfg_update), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         cfg_pulses = 0;
    int         cfg_hi     = 0;
    logic       cfg_prev   = 1'b0;
    logic [7:0] exp_byte;

    // Scoreboard monitor: one line per completed response transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_update) cfg_hi++;
            if (cfg_update && !cfg_prev) cfg_pulses++;
            cfg_prev = cfg_update;
            if (tx_valid && tx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got %02h, no response expected", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (tx_data !== exp_byte) begin
                        n_fail++;
                        $display("FAIL resp_byte: got %02h, expected %02h", tx_data, exp_byte);
                    end else begin
                        $display("txn resp=%02h expected=%02h ok", tx_data, exp_byte);
                    end
                end
            end
        end else begin
            cfg_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(dh);
        send_byte(dl);
        send_byte(chk);
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        ok = (exp_q.size() == 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({phase_inc, amplitude, pwm_en, tx_valid, tx_data, cfg_update, err_cnt} !==
            {16'h0100, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_in: got pinc=%h amp=%h en=%b txv=%b txd=%h cfg=%b err=%h, expected 0100 ff 0 0 00 0 00",
                     phase_inc, amplitude, pwm_en, tx_valid, tx_data, cfg_update, err_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({phase_inc, amplitude, pwm_en, tx_valid, err_cnt} !== {16'h0100, 8'hFF, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_out: got pinc=%h amp=%h en=%b txv=%b err=%h", phase_inc, amplitude, pwm_en, tx_valid, err_cnt);
        end
    endtask

    task automatic test_write_phase;
        int p0, h0;
        bit ok;
        p0 = cfg_pulses; h0 = cfg_hi;
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h12, 8'h34, 8'h01 ^ 8'h12 ^ 8'h34);
        n_checks++;
        if (phase_inc !== 16'h0100 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_early: got pinc=%h txv=%b, expected 0100 0 one cycle after CHK", phase_inc, tx_valid);
        end
        @(negedge clk);
        n_checks++;
        if (phase_inc !== 16'h1234 || tx_valid !== 1'b1 || cfg_update !== 1'b1) begin
            n_fail++;
            $display("FAIL phase_latency: got pinc=%h txv=%b cfg=%b, expected 1234 1 1", phase_inc, tx_valid, cfg_update);
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL phase_drain: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
        n_checks++;
        if (cfg_pulses - p0 != 1 || cfg_hi - h0 != 1) begin
            n_fail++;
            $display("FAIL phase_cfg_pulse: got %0d pulses %0d cycles, expected 1 1", cfg_pulses - p0, cfg_hi - h0);
        end
    endtask

    task automatic test_amp_pwm;
        int p0;
        bit ok;
        p0 = cfg_pulses;
        exp_q.push_back(8'h06);
        send_frame(8'h02, 8'h00, 8'h40, 8'h42);
        drain(ok);
        exp_q.push_back(8'h06);
        send_frame(8'h03, 8'h00, 8'h01, 8'h02);
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL amp_pwm_drain: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
        n_checks++;
        if (amplitude !== 8'h40 || pwm_en !== 1'b1 || cfg_pulses - p0 != 2) begin
            n_fail++;
            $display("FAIL amp_pwm: got amp=%h en=%b pulses=%0d, expected 40 1 2", amplitude, pwm_en, cfg_pulses - p0);
        end
    endtask

    task automatic test_bad_chk;
        int p0;
        bit ok;
        p0 = cfg_pulses;
        exp_q.push_back(8'h15);
        send_frame(8'h01, 8'h12, 8'h34, 8'h00);
        drain(ok);
        n_checks++;
        if (!ok || phase_inc !== 16'h1234 || err_cnt !== 8'd1 || cfg_pulses != p0) begin
            n_fail++;
            $display("FAIL bad_chk: got drained=%b pinc=%h err=%h pulses=%0d, expected 1 1234 01 0",
                     ok, phase_inc, err_cnt, cfg_pulses - p0);
            exp_q.delete();
        end
    endtask

    task automatic test_timeout;
        bit ok;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TMO + 5) @(negedge clk);
        exp_q.push_back(8'h80);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        drain(ok);
        n_checks++;
        if (!ok || err_cnt !== 8'd1 || phase_inc !== 16'h1234) begin
            n_fail++;
            $display("FAIL timeout: got drained=%b err=%h pinc=%h, expected 1 01 1234", ok, err_cnt, phase_inc);
            exp_q.delete();
        end
    endtask

    task automatic test_hold_ready;
        int  errs;
        bit  ok;
        logic [7:0] junk [4];
        junk[0] = 8'hA5; junk[1] = 8'h01; junk[2] = 8'h00; junk[3] = 8'h00;
        errs = 0;
        tx_ready = 1'b0;
        exp_q.push_back(8'h06);
        send_frame(8'h02, 8'h00, 8'h40, 8'h42);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h06) errs++;
            rx_valid = (i >= 10 && i < 18 && i[0] == 1'b0);
            rx_data  = junk[(i - 10) / 2 % 4];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles, expected 0", errs);
        end
        tx_ready = 1'b1;
        drain(ok);
        exp_q.push_back(8'h80);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL hold_drain: got %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_unknown_cmd;
        bit ok;
        exp_q.push_back(8'h15);
        send_frame(8'h07, 8'h11, 8'h22, 8'h07 ^ 8'h11 ^ 8'h22);
        drain(ok);
        n_checks++;
        if (!ok || err_cnt !== 8'd2 || phase_inc !== 16'h1234 || amplitude !== 8'h40) begin
            n_fail++;
            $display("FAIL unknown_cmd: got drained=%b err=%h pinc=%h amp=%h, expected 1 02 1234 40",
                     ok, err_cnt, phase_inc, amplitude);
            exp_q.delete();
        end
    endtask

    task automatic test_status_silent;
        bit ok;
        exp_q.push_back(8'h06);
        send_frame(8'h02, 8'h77, 8'h00, 8'h02 ^ 8'h77);
        drain(ok);
        exp_q.push_back(8'h06);
        send_frame(8'h03, 8'h00, 8'hFE, 8'h03 ^ 8'hFE);
        drain(ok);
        exp_q.push_back(8'h01);
        send_frame(8'h04, 8'h00, 8'h00, 8'h04);
        drain(ok);
        n_checks++;
        if (!ok || amplitude !== 8'h00 || pwm_en !== 1'b0) begin
            n_fail++;
            $display("FAIL status_silent: got drained=%b amp=%h en=%b, expected 1 00 0", ok, amplitude, pwm_en);
            exp_q.delete();
        end
    endtask

    task automatic test_err_saturate;
        bit ok;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'h15);
            send_frame(8'h01, 8'h00, 8'h00, 8'hFF);
            drain(ok);
        end
        n_checks++;
        if (!ok || err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate: got drained=%b err=%h, expected 1 ff", ok, err_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAB);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({phase_inc, amplitude, pwm_en, tx_valid, cfg_update, err_cnt} !==
            {16'h0100, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_midframe: got pinc=%h amp=%h en=%b txv=%b cfg=%b err=%h, expected 0100 ff 0 0 0 00",
                     phase_inc, amplitude, pwm_en, tx_valid, cfg_update, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h56, 8'h78, 8'h01 ^ 8'h56 ^ 8'h78);
        drain(ok);
        n_checks++;
        if (!ok || phase_inc !== 16'h5678) begin
            n_fail++;
            $display("FAIL after_reset_frame: got drained=%b pinc=%h, expected 1 5678", ok, phase_inc);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_write_phase();
        test_amp_pwm();
        test_bad_chk();
        test_timeout();
        test_hold_ready();
        test_unknown_cmd();
        test_status_silent();
        test_err_saturate();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
